sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_pkg.sv | 38 +++
 rtl/sw_debounce_if.sv | 25 ++
 rtl/sw_debounce_bit.sv | 75 +++++++
 rtl/sw_debounce.sv | 54 +++++
 tb/tb_sw_debounce.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
package sw_debounce_pkg;

   // Default build: 16 switches, tick every 2^16 clocks, 4 agreeing ticks.
   localparam int DEF_WIDTH      = 16;
   localparam int DEF_TICK_DIV   = 16;
   localparam int DEF_STABLE_CNT = 4;

   // Width of the per-bit stability counter (supports STABLE_CNT up to 15).
   localparam int CNT_W = 4;

   // What the per-bit stability counter does this cycle.
   typedef enum logic [1:0] {
      CNT_HOLD   = 2'd0,  // not a tick cycle, nothing moves
      CNT_CLEAR  = 2'd1,  // sample agrees with current level, glitch rejected
      CNT_INC    = 2'd2,  // sample differs, not yet long enough
      CNT_ACCEPT = 2'd3   // sample differed for the full window, flip level
   } cnt_action_e;

   // Decide the counter action from the tick strobe, the level comparison
   // and whether the counter already sits at its last step.
   function automatic cnt_action_e cnt_action(input logic tick,
                                              input logic differ,
                                              input logic at_last);
      cnt_action_e act;
      if (!tick) begin
         act = CNT_HOLD;
      end else if (!differ) begin
         act = CNT_CLEAR;
      end else if (at_last) begin
         act = CNT_ACCEPT;
      end else begin
         act = CNT_INC;
      end
      return act;
   endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bundle: raw board inputs in, debounced levels and edge pulses out.
interface sw_debounce_if
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic [WIDTH-1:0] sw_raw;     // raw asynchronous switches/buttons
   logic [WIDTH-1:0] sw_o;       // debounced stable level
   logic [WIDTH-1:0] rise_o;     // one-cycle pulse on accepted 0->1
   logic [WIDTH-1:0] fall_o;     // one-cycle pulse on accepted 1->0
   logic             changed_o;  // OR of all rise/fall pulses
   logic             tick_o;     // sample-tick strobe

   // Board / consumer side: drives switches, observes results.
   modport master (
      output sw_raw,
      input  sw_o, rise_o, fall_o, changed_o, tick_o
   );

   // Debouncer side.
   modport slave (
      input  sw_raw,
      output sw_o, rise_o, fall_o, changed_o, tick_o
   );
endinterface

// File: rtl/sw_debounce_bit.sv
// One debounced switch: 2-flop synchronizer, tick-gated stability counter,
// accepted level and registered rise/fall pulses.
module sw_debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int STABLE_CNT = DEF_STABLE_CNT
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_raw,
   input  logic i_tick,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;
   cnt_action_e      w_action;

   // Bring the asynchronous switch into the clk domain before any use.
   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the sync chain.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Classify this cycle: hold, reject glitch, count, or accept the change.
   // NOTE: the combinational output is assigned on every path (here via a single
   // unconditional assignment) so no latch is inferred.
   always_comb begin
      w_action = cnt_action(i_tick, (r_sync2 != r_level), (r_cnt == CNT_LAST));
   end

   // Stability counter, accepted level and one-cycle edge pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (w_action)
            CNT_CLEAR:  r_cnt <= '0;
            CNT_INC:    r_cnt <= r_cnt + CNT_W'(1);
            CNT_ACCEPT: begin
               r_cnt   <= '0;
               r_level <= ~r_level;
               r_rise  <= ~r_level;
               r_fall  <= r_level;
            end
            default:    r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/sw_debounce.sv
// Multi-bit switch debouncer: shared sample-tick prescaler feeding one
// sw_debounce_bit per switch, plus the combined change strobe.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int STABLE_CNT = DEF_STABLE_CNT
) (
   input  logic          clk,
   input  logic          rstn,
   sw_debounce_if.slave  bus
);

   logic [TICK_DIV-1:0] r_presc;
   logic                w_tick;
   logic [WIDTH-1:0]    w_level;
   logic [WIDTH-1:0]    w_rise;
   logic [WIDTH-1:0]    w_fall;

   // Free-running prescaler; wraps from all-ones back to zero on its own.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + TICK_DIV'(1);
      end
   end

   // Tick is the cycle the prescaler sits at all-ones.
   assign w_tick = &r_presc;

   // One independent debouncer per switch, all sharing the same tick.
   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      sw_debounce_bit #(
         .STABLE_CNT (STABLE_CNT)
      ) u_bit (
         .clk     (clk),
         .rstn    (rstn),
         .i_raw   (bus.sw_raw[g]),
         .i_tick  (w_tick),
         .o_level (w_level[g]),
         .o_rise  (w_rise[g]),
         .o_fall  (w_fall[g])
      );
   end

   assign bus.sw_o      = w_level;
   assign bus.rise_o    = w_rise;
   assign bus.fall_o    = w_fall;
   assign bus.changed_o = |(w_rise | w_fall);
   assign bus.tick_o    = w_tick;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with TICK_DIV=2 (tick every 4 clocks),
// STABLE_CNT=4, WIDTH=16. All actions happen on the falling edge; k below is
// the number of rising edges since the most recent reset release.
module tb_sw_debounce;

   logic clk;
   logic rstn;
   int   n_checks;
   int   n_errors;

   sw_debounce_if #(.WIDTH(16)) u_if ();

   sw_debounce #(
      .WIDTH      (16),
      .TICK_DIV   (2),
      .STABLE_CNT (4)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (u_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check16({tag, "_sw"},   u_if.sw_o,      16'h0000);
      check16({tag, "_rise"}, u_if.rise_o,    16'h0000);
      check16({tag, "_fall"}, u_if.fall_o,    16'h0000);
      check1 ({tag, "_chg"},  u_if.changed_o, 1'b0);
      check1 ({tag, "_tick"}, u_if.tick_o,    1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      // Reset with all switches high: everything stays low.
      rstn = 1'b0;
      u_if.sw_raw = 16'hFFFF;
      step(1);
      check_all_zero("rst_hold_a");
      step(3);
      check_all_zero("rst_hold_b");

      // Release: inputs high at release are debounced as ordinary presses.
      rstn = 1'b1;                                   // k=0
      step(1);                                       // k=1
      check1 ("rel_tick_k1", u_if.tick_o, 1'b0);
      check16("rel_rise_k1", u_if.rise_o, 16'h0000);
      step(2);                                       // k=3
      check1 ("rel_tick_k3", u_if.tick_o, 1'b1);
      step(1);                                       // k=4
      check1 ("rel_tick_k4", u_if.tick_o, 1'b0);
      step(11);                                      // k=15
      check16("rel_sw_k15", u_if.sw_o, 16'h0000);
      step(1);                                       // k=16
      check16("rel_sw_k16",   u_if.sw_o,   16'hFFFF);
      check16("rel_rise_k16", u_if.rise_o, 16'hFFFF);
      check16("rel_fall_k16", u_if.fall_o, 16'h0000);
      check1 ("rel_chg_k16",  u_if.changed_o, 1'b1);
      step(1);                                       // k=17
      check16("rel_rise_k17", u_if.rise_o, 16'h0000);
      check1 ("rel_chg_k17",  u_if.changed_o, 1'b0);
      check16("rel_sw_k17",   u_if.sw_o,   16'hFFFF);

      // Asynchronous reset clears outputs immediately.
      rstn = 1'b0;
      u_if.sw_raw = 16'h0000;
      #1;
      check_all_zero("rst_async");
      step(2);
      check_all_zero("rst_async_hold");
      rstn = 1'b1;                                   // k=0

      // Clean press on bit 3.
      step(1);                                       // k=1
      u_if.sw_raw = 16'h0008;
      step(14);                                      // k=15
      check16("press_sw_k15", u_if.sw_o, 16'h0000);
      step(1);                                       // k=16
      check16("press_sw_k16",   u_if.sw_o,   16'h0008);
      check16("press_rise_k16", u_if.rise_o, 16'h0008);
      check16("press_fall_k16", u_if.fall_o, 16'h0000);
      check1 ("press_chg_k16",  u_if.changed_o, 1'b1);
      step(1);                                       // k=17
      check16("press_rise_k17", u_if.rise_o, 16'h0000);
      check1 ("press_chg_k17",  u_if.changed_o, 1'b0);
      check16("press_sw_k17",   u_if.sw_o,   16'h0008);

      // Bounce on bit 0: high for 9 cycles reaches only 3 differing ticks.
      u_if.sw_raw = 16'h0009;
      for (int k = 18; k <= 36; k++) begin
         step(1);
         check16("bounce_sw", u_if.sw_o, 16'h0008);
         check1 ("bounce_chg", u_if.changed_o, 1'b0);
         if (k == 26) u_if.sw_raw = 16'h0008;
      end

      // Press then release on bit 15.
      u_if.sw_raw = 16'h8008;                        // k=36
      step(15);                                      // k=51
      check16("b15_sw_k51", u_if.sw_o, 16'h0008);
      step(1);                                       // k=52
      check16("b15_sw_k52",   u_if.sw_o,   16'h8008);
      check16("b15_rise_k52", u_if.rise_o, 16'h8000);
      step(1);                                       // k=53
      check16("b15_rise_k53", u_if.rise_o, 16'h0000);
      u_if.sw_raw = 16'h0008;
      step(14);                                      // k=67
      check16("rel15_sw_k67",   u_if.sw_o,   16'h8008);
      check16("rel15_fall_k67", u_if.fall_o, 16'h0000);
      step(1);                                       // k=68
      check16("rel15_fall_k68", u_if.fall_o, 16'h8000);
      check16("rel15_rise_k68", u_if.rise_o, 16'h0000);
      check16("rel15_sw_k68",   u_if.sw_o,   16'h0008);
      check1 ("rel15_chg_k68",  u_if.changed_o, 1'b1);
      step(1);                                       // k=69
      check16("rel15_fall_k69", u_if.fall_o, 16'h0000);
      check1 ("rel15_chg_k69",  u_if.changed_o, 1'b0);

      // Bits 0 and 8 pressed in the same cycle.
      u_if.sw_raw = 16'h0109;
      step(14);                                      // k=83
      check16("sim_sw_k83", u_if.sw_o, 16'h0008);
      step(1);                                       // k=84
      check16("sim_rise_k84", u_if.rise_o, 16'h0101);
      check16("sim_fall_k84", u_if.fall_o, 16'h0000);
      check16("sim_sw_k84",   u_if.sw_o,   16'h0109);
      check1 ("sim_chg_k84",  u_if.changed_o, 1'b1);
      step(1);                                       // k=85
      check16("sim_rise_k85", u_if.rise_o, 16'h0000);
      check1 ("sim_chg_k85",  u_if.changed_o, 1'b0);

      // Bit 5 reaches 3 differing ticks, then reset discards the count.
      u_if.sw_raw = 16'h0129;
      step(12);                                      // k=97
      check16("mid_sw_k97", u_if.sw_o, 16'h0109);
      rstn = 1'b0;
      #1;
      check_all_zero("mid_rst");
      step(2);
      check_all_zero("mid_rst_hold");
      rstn = 1'b1;                                   // k=0
      step(1);                                       // k=1
      check16("mid_rise_k1", u_if.rise_o, 16'h0000);
      check16("mid_sw_k1",   u_if.sw_o,   16'h0000);
      step(3);                                       // k=4
      check16("mid_sw_k4", u_if.sw_o, 16'h0000);
      step(8);                                       // k=12
      check16("mid_sw_k12", u_if.sw_o, 16'h0000);
      step(3);                                       // k=15
      check16("mid_sw_k15", u_if.sw_o, 16'h0000);
      step(1);                                       // k=16
      check16("mid_sw_k16",   u_if.sw_o,   16'h0129);
      check16("mid_rise_k16", u_if.rise_o, 16'h0129);
      step(1);                                       // k=17
      check16("mid_rise_k17", u_if.rise_o, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
